// File: rtl/t04_mem_request_ctrl.sv
// Shared-port fetch/load/store sequencer with core freeze; 2 cycles per ALU op, 4 per memory op at 0-wait.
// Memory stalls hold the FSM (and freeze) until ack; a missing ack past TIMEOUT or a misaligned access parks in ERR until reset.
module t04_mem_request_ctrl #(
  parameter int          ADDR_W      = 32,
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ack,
  input  logic              d_ack,
  input  logic [31:0]       instruction,
  input  logic [31:0]       memload,
  input  logic [ADDR_W-1:0] PC,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [31:0]       stored_data,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  output logic [ADDR_W-1:0] final_address,
  output logic [31:0]       mem_store,
  output logic [3:0]        byte_en,
  output logic              rd_req,
  output logic              wr_req,
  output logic [31:0]       instruction_out,
  output logic [31:0]       load_data,
  output logic              freeze,
  output logic              bus_err,
  output logic              misalign_err
);

  localparam int               CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {FETCH, EXEC, DATA, DONE, ERR} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        off;
  logic [4:0]        sh;
  logic              is_mem, is_store, is_half, is_word, misaligned, expired;
  logic [31:0]       shifted, ext;
  logic [ADDR_W-1:0] pc_word, data_word;
  logic              unused_bits;

  assign off         = mem_address[1:0];
  assign sh          = {off, 3'b000};
  assign is_mem      = MemRead | MemWrite;
  assign is_store    = MemWrite;
  assign is_half     = (mem_size == 2'b01);
  assign is_word     = mem_size[1];
  assign misaligned  = (is_half & off[0]) | (is_word & (off != 2'b00));
  assign expired     = (cnt == CNT_MAX);
  assign pc_word     = {PC[ADDR_W-1:2], 2'b00};
  assign data_word   = {mem_address[ADDR_W-1:2], 2'b00};
  assign unused_bits = ^PC[1:0];
  assign shifted     = memload >> sh;

  always_comb begin
    ext = shifted;
    case (mem_size)
      2'b00:   ext = {{24{shifted[7] & ~mem_unsigned}}, shifted[7:0]};
      2'b01:   ext = {{16{shifted[15] & ~mem_unsigned}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    rd_req        = 1'b0;
    wr_req        = 1'b0;
    byte_en       = 4'b0000;
    mem_store     = 32'h0;
    final_address = pc_word;
    freeze        = 1'b1;
    case (state)
      FETCH: begin
        rd_req = 1'b1;
        if (i_ack)        state_nxt = EXEC;
        else if (expired) state_nxt = ERR;
      end
      EXEC: begin
        if (!is_mem) begin
          freeze    = 1'b0;
          state_nxt = FETCH;
        end else if (misaligned) begin
          state_nxt = ERR;
        end else begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        final_address = data_word;
        if (is_store) begin
          wr_req    = 1'b1;
          mem_store = stored_data << sh;
          case (mem_size)
            2'b00:   byte_en = 4'b0001 << off;
            2'b01:   byte_en = 4'b0011 << off;
            default: byte_en = 4'b1111;
          endcase
        end else begin
          rd_req = 1'b1;
        end
        if (d_ack)        state_nxt = DONE;
        else if (expired) state_nxt = ERR;
      end
      DONE: begin
        freeze    = 1'b0;
        state_nxt = FETCH;
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt             <= '0;
      instruction_out <= RESET_INSTR;
      load_data       <= 32'h0;
      bus_err         <= 1'b0;
      misalign_err    <= 1'b0;
    end else begin
      // Any state change restarts the wait count; it only matters in FETCH and DATA.
      if (state != state_nxt)
        cnt <= '0;
      else if ((state == FETCH || state == DATA) && !expired)
        cnt <= cnt + 1'b1;
      if (state == FETCH && i_ack)
        instruction_out <= instruction;
      if (state == DATA && d_ack && !is_store)
        load_data <= ext;
      if (expired && ((state == FETCH && !i_ack) || (state == DATA && !d_ack)))
        bus_err <= 1'b1;
      if (state == EXEC && is_mem && misaligned)
        misalign_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_t04_mem_request_ctrl.sv
// Directed bench for t04_mem_request_ctrl: a phase-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_t04_mem_request_ctrl;
  localparam int          TO = 4;
  localparam logic [31:0] RI = 32'h0000_0013;
  localparam int M_FETCH = 0, M_EXEC = 1, M_DATA = 2, M_DONE = 3, M_ERR = 4;

  logic        clk = 1'b0;
  logic        rst, i_ack, d_ack, MemRead, MemWrite, mem_unsigned;
  logic [31:0] instruction, memload, PC, mem_address, stored_data;
  logic [1:0]  mem_size;
  logic [31:0] final_address, mem_store, instruction_out, load_data;
  logic [3:0]  byte_en;
  logic        rd_req, wr_req, freeze, bus_err, misalign_err;

  int errors = 0;
  int checks = 0;

  t04_mem_request_ctrl #(.ADDR_W(32), .TIMEOUT(TO), .RESET_INSTR(RI)) dut (
    .clk(clk), .rst(rst), .i_ack(i_ack), .d_ack(d_ack),
    .instruction(instruction), .memload(memload), .PC(PC),
    .mem_address(mem_address), .stored_data(stored_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .final_address(final_address),
    .mem_store(mem_store), .byte_en(byte_en), .rd_req(rd_req),
    .wr_req(wr_req), .instruction_out(instruction_out),
    .load_data(load_data), .freeze(freeze), .bus_err(bus_err),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Load result by arithmetic: pick the addressed bytes, then apply two's-complement if signed.
  function automatic logic [31:0] m_ext(input logic [31:0] w, input logic [1:0] o,
                                        input logic [1:0] sz, input logic uns);
    longint v;
    int     nb;
    nb = nbytes(sz);
    v  = w >> (8 * o);
    if (nb == 4) return w;
    v = v % (longint'(1) << (8 * nb));
    if (!uns && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  int          ph, waited;
  logic [31:0] m_instr, m_load;
  logic        m_berr, m_merr;
  bit          started = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      ph = M_FETCH; waited = 0; m_instr = RI; m_load = 0; m_berr = 0; m_merr = 0;
    end else begin
      case (ph)
        M_FETCH:
          if (i_ack) begin m_instr = instruction; ph = M_EXEC; end
          else if (waited >= TO) begin m_berr = 1; ph = M_ERR; end
          else waited++;
        M_EXEC:
          if (!MemRead && !MemWrite) begin ph = M_FETCH; waited = 0; end
          else if (mem_address % nbytes(mem_size) != 0) begin m_merr = 1; ph = M_ERR; end
          else begin ph = M_DATA; waited = 0; end
        M_DATA:
          if (d_ack) begin
            if (!MemWrite) m_load = m_ext(memload, mem_address[1:0], mem_size, mem_unsigned);
            ph = M_DONE;
          end else if (waited >= TO) begin m_berr = 1; ph = M_ERR; end
          else waited++;
        M_DONE: begin ph = M_FETCH; waited = 0; end
        default: ;
      endcase
    end
    started = 1'b1;
  end

  logic [31:0] e_fa, e_ms;
  logic [3:0]  e_be;
  logic        e_rd, e_wr, e_frz;
  int          c_off, c_nb;

  always @(negedge clk) begin
    if (started) begin
      c_off = int'(mem_address[1:0]);
      c_nb  = nbytes(mem_size);
      e_fa  = PC - (PC % 4);
      e_rd  = (ph == M_FETCH);
      e_wr  = 1'b0;
      e_be  = 4'b0000;
      e_ms  = 32'h0;
      e_frz = !(ph == M_DONE || (ph == M_EXEC && !MemRead && !MemWrite));
      if (ph == M_DATA) begin
        e_fa = mem_address - (mem_address % 4);
        if (MemWrite) begin
          e_wr = 1'b1;
          e_ms = stored_data * (32'd1 << (8 * c_off));
          for (int i = 0; i < 4; i++) e_be[i] = (c_nb == 4) || (i >= c_off && i < c_off + c_nb);
        end else begin
          e_rd = 1'b1;
        end
      end
      chk("final_address", final_address, e_fa);
      chk("rd_req", 32'(rd_req), 32'(e_rd));
      chk("wr_req", 32'(wr_req), 32'(e_wr));
      chk("byte_en", 32'(byte_en), 32'(e_be));
      chk("mem_store", mem_store, e_ms);
      chk("freeze", 32'(freeze), 32'(e_frz));
      chk("instruction_out", instruction_out, m_instr);
      chk("load_data", load_data, m_load);
      chk("bus_err", 32'(bus_err), 32'(m_berr));
      chk("misalign_err", 32'(misalign_err), 32'(m_merr));
    end
  end

  // Starts and ends in FETCH; captures the first DATA cycle's outputs and freeze in the commit cycle.
  task automatic run_instr(input logic mr, input logic mw, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] ml,
                           input int fw, input int dw,
                           output logic [31:0] cap_fa, output logic [31:0] cap_ms,
                           output logic [3:0] cap_be, output logic cap_rd, output logic cap_wr,
                           output logic cap_fz);
    MemRead = mr; MemWrite = mw; mem_size = sz; mem_unsigned = uns;
    mem_address = addr; stored_data = sd; memload = ml;
    cap_fa = 0; cap_ms = 0; cap_be = 0; cap_rd = 0; cap_wr = 0;
    i_ack = 0;
    repeat (fw) tick;
    i_ack = 1;
    tick;
    i_ack = 0;
    if (!(mr | mw)) begin
      cap_fz = freeze;
      tick;
    end else begin
      tick;
      cap_fa = final_address; cap_ms = mem_store; cap_be = byte_en;
      cap_rd = rd_req; cap_wr = wr_req;
      repeat (dw) tick;
      d_ack = 1;
      tick;
      d_ack = 0;
      cap_fz = freeze;
      tick;
    end
  endtask

  initial begin
    logic [31:0] c_fa, c_ms;
    logic [3:0]  c_be;
    logic        c_rd, c_wr, c_fz;
    rst = 1; i_ack = 0; d_ack = 0; instruction = 0; memload = 0; PC = 32'h40;
    mem_address = 0; stored_data = 0; MemRead = 0; MemWrite = 0; mem_size = 2'b10; mem_unsigned = 0;
    tick; tick;
    chk("rst_freeze", 32'(freeze), 1);
    chk("rst_rd_req", 32'(rd_req), 1);
    chk("rst_wr_req", 32'(wr_req), 0);
    chk("rst_byte_en", 32'(byte_en), 0);
    chk("rst_mem_store", mem_store, 0);
    chk("rst_instr", instruction_out, 32'h0000_0013);
    chk("rst_load", load_data, 0);
    chk("rst_errs", 32'({bus_err, misalign_err}), 0);

    rst = 0; instruction = 32'h0050_0093; i_ack = 1;
    for (int k = 0; k < 3; k++) begin
      chk("zw_addr", final_address, 32'h40);
      chk("zw_freeze_fetch", 32'(freeze), 1);
      tick;
      chk("zw_instr", instruction_out, 32'h0050_0093);
      chk("zw_freeze_exec", 32'(freeze), 0);
      tick;
    end

    run_instr(1, 0, 2'b00, 0, 32'h1003, 32'h0, 32'h80FF_FF12, 0, 2, c_fa, c_ms, c_be, c_rd, c_wr, c_fz);
    chk("lb_addr", c_fa, 32'h1000);
    chk("lb_rd", 32'(c_rd), 1);
    chk("lb_done_freeze", 32'(c_fz), 0);
    chk("lb_data", load_data, 32'hFFFF_FF80);

    run_instr(0, 1, 2'b01, 0, 32'h2002, 32'h0000_BEEF, 32'h0, 0, 1, c_fa, c_ms, c_be, c_rd, c_wr, c_fz);
    chk("sh_be", 32'(c_be), 32'hC);
    chk("sh_data", c_ms, 32'hBEEF_0000);
    chk("sh_wr", 32'(c_wr), 1);
    chk("sh_rd", 32'(c_rd), 0);
    chk("sh_addr", c_fa, 32'h2000);

    run_instr(1, 0, 2'b01, 1, 32'h2002, 32'h0, 32'hBEEF_0000, 1, 0, c_fa, c_ms, c_be, c_rd, c_wr, c_fz);
    chk("lhu_data", load_data, 32'h0000_BEEF);

    PC = 32'h47;
    run_instr(1, 0, 2'b01, 0, 32'h1002, 32'h0, 32'h8001_7F00, 0, 0, c_fa, c_ms, c_be, c_rd, c_wr, c_fz);
    chk("lh_data", load_data, 32'hFFFF_8001);
    run_instr(1, 0, 2'b00, 1, 32'h1001, 32'h0, 32'h1234_F056, 0, 0, c_fa, c_ms, c_be, c_rd, c_wr, c_fz);
    chk("lbu_data", load_data, 32'h0000_00F0);
    run_instr(1, 1, 2'b00, 0, 32'h2001, 32'h1234_56A5, 32'h0, 2, 0, c_fa, c_ms, c_be, c_rd, c_wr, c_fz);
    chk("sb_be", 32'(c_be), 32'h2);
    chk("sb_data", c_ms, 32'h3456_A500);
    chk("sb_no_load", load_data, 32'h0000_00F0);
    run_instr(0, 1, 2'b11, 0, 32'h2004, 32'hCAFE_F00D, 32'h0, 0, TO, c_fa, c_ms, c_be, c_rd, c_wr, c_fz);
    chk("sw_be", 32'(c_be), 32'hF);
    chk("sw_data", c_ms, 32'hCAFE_F00D);
    chk("data_edge_no_err", 32'(bus_err), 0);
    run_instr(1, 0, 2'b10, 0, 32'h3000, 32'h0, 32'h8765_4321, TO, 0, c_fa, c_ms, c_be, c_rd, c_wr, c_fz);
    chk("lw_data", load_data, 32'h8765_4321);
    run_instr(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'h0, 1, 0, c_fa, c_ms, c_be, c_rd, c_wr, c_fz);
    chk("alu_commit_freeze", 32'(c_fz), 0);

    MemRead = 1; MemWrite = 0; mem_size = 2'b10; mem_address = 32'h3000;
    memload = 32'h1111_2222; instruction = 32'hABCD_0003; i_ack = 1;
    tick;
    i_ack = 0;
    tick;
    chk("rdd_in_data", 32'(rd_req), 1);
    d_ack = 1; rst = 1;
    tick;
    chk("rdd_load", load_data, 0);
    chk("rdd_instr", instruction_out, 32'h0000_0013);
    chk("rdd_freeze", 32'(freeze), 1);
    chk("rdd_rd", 32'(rd_req), 1);
    chk("rdd_addr", final_address, 32'h44);
    rst = 0; d_ack = 0;

    mem_address = 32'h3002; i_ack = 1;
    tick;
    i_ack = 0;
    chk("mis_exec_freeze", 32'(freeze), 1);
    tick;
    chk("mis_err", 32'(misalign_err), 1);
    chk("mis_no_rd", 32'(rd_req), 0);
    i_ack = 1; d_ack = 1;
    repeat (4) tick;
    chk("mis_hold_freeze", 32'(freeze), 1);
    chk("mis_hold_no_rd", 32'(rd_req), 0);
    chk("mis_no_bus_err", 32'(bus_err), 0);
    i_ack = 0; d_ack = 0; MemRead = 0; rst = 1;
    tick;
    rst = 0;
    chk("mis_cleared", 32'(misalign_err), 0);

    for (int k = 1; k <= 5; k++) begin
      chk("to_no_err_yet", 32'(bus_err), 0);
      chk("to_fetching", 32'(rd_req), 1);
      tick;
    end
    chk("to_bus_err", 32'(bus_err), 1);
    chk("to_err_no_rd", 32'(rd_req), 0);
    repeat (3) tick;
    chk("to_sticky", 32'(bus_err), 1);
    chk("to_err_freeze", 32'(freeze), 1);
    rst = 1;
    tick;
    rst = 0;
    instruction = 32'h0010_0113;
    run_instr(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'h0, TO, 0, c_fa, c_ms, c_be, c_rd, c_wr, c_fz);
    chk("to_edge_no_err", 32'(bus_err), 0);
    chk("to_edge_instr", instruction_out, 32'h0010_0113);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
